task2_vector_checker: RTL and testbench

//  Board-level self-test wrapped around the Task2 4-in/2-out logic block.

---
 rtl/task2_vector_checker.sv | 215 +++++++++++++++++++++
 tb/tb_task2_vector_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task2_vector_checker.sv
// task2_vector_checker
//   Board-level self-test for the Task2 4-in/2-out logic block. Sweeps the
//   Task2 inputs {a,b,c,d} through codes 0..15 (a = MSB), samples x,y after a
//   settle delay, compares them against golden truth-table masks and reports
//   an error count plus pass/done flags.
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous reset, active low
//   start      in   begin a 16-vector sweep (accepted in IDLE/DONE only)
//   step       in   advance one vector (manual mode, WAIT state only)
//   mode_run   in   1 = auto-advance every TICK_DIV cycles, 0 = advance on step
//   a,b,c,d    out  registered stimulus to Task2, {a,b,c,d} = idx
//   x,y        in   Task2 outputs under test
//   idx        out  current vector index
//   busy       out  sweep in progress
//   done       out  sweep finished
//   pass       out  valid with done: no failing vector
//   err_count  out  number of failing vectors (0..16)
//   err_flag   out  one-cycle pulse after a failing CHECK
//   err_vec    out  per-vector fail record, only with TASK2_CHK_ERRVEC_EN
//
// Build option
//   TASK2_CHK_ERRVEC_EN : adds err_vec[15:0], bit i set when vector i fails.
//
// States
//   S_IDLE   | after reset, waiting for start
//   S_SETTLE | vector applied, waiting SETTLE cycles for Task2 to settle
//   S_CHECK  | one cycle: compare x,y against the golden masks
//   S_WAIT   | waiting for divider tick (run) or step pulse (manual)
//   S_DONE   | sweep complete, results held until next start
module task2_vector_checker #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] X_MASK   = 16'hCF00,
  parameter logic [15:0] Y_MASK   = 16'h0F54
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       step,
  input  logic       mode_run,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       x,
  input  logic       y,
  output logic [3:0] idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       err_flag
`ifdef TASK2_CHK_ERRVEC_EN
  ,
  output logic [15:0] err_vec
`endif
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // Down-counters are loaded with N-1 and terminate at zero, so a state
  // guarded by them lasts exactly N cycles.
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       idx_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [SET_W-1:0] settle_cnt, settle_nxt;
  logic             busy_nxt, done_nxt, pass_nxt, err_flag_nxt;
  logic [4:0]       err_count_nxt;
  logic             mismatch;

`ifdef TASK2_CHK_ERRVEC_EN
  logic [15:0] err_vec_q, err_vec_nxt;
  assign err_vec = err_vec_q;
`else
  // No per-vector record is kept; err_count alone summarises the sweep.
`endif

  // A vector counts once even when both outputs are wrong.
  assign mismatch = (x != X_MASK[idx]) || (y != Y_MASK[idx]);

  // Stimulus is idx itself, so it changes on the same edge as idx.
  assign a = idx[3];
  assign b = idx[2];
  assign c = idx[1];
  assign d = idx[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      div_cnt    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      err_flag   <= 1'b0;
`ifdef TASK2_CHK_ERRVEC_EN
      err_vec_q  <= 16'd0;
`endif
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      div_cnt    <= div_nxt;
      settle_cnt <= settle_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_count_nxt;
      err_flag   <= err_flag_nxt;
`ifdef TASK2_CHK_ERRVEC_EN
      err_vec_q  <= err_vec_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    div_nxt       = div_cnt;
    settle_nxt    = settle_cnt;
    busy_nxt      = busy;
    done_nxt      = done;
    pass_nxt      = pass;
    err_count_nxt = err_count;
    err_flag_nxt  = 1'b0;
`ifdef TASK2_CHK_ERRVEC_EN
    err_vec_nxt   = err_vec_q;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        // start wins over a simultaneous step, which is simply not looked at
        if (start) begin
          state_nxt     = S_SETTLE;
          idx_nxt       = 4'd0;
          settle_nxt    = SET_LOAD;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          pass_nxt      = 1'b0;
          err_count_nxt = 5'd0;
`ifdef TASK2_CHK_ERRVEC_EN
          err_vec_nxt   = 16'd0;
`endif
        end
      end

      S_SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = S_CHECK;
        end else begin
          settle_nxt = settle_cnt - SET_W'(1);
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          err_count_nxt = err_count + 5'd1;
          err_flag_nxt  = 1'b1;
`ifdef TASK2_CHK_ERRVEC_EN
          err_vec_nxt[idx] = 1'b1;
`endif
        end
        if (idx == 4'd15) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_count_nxt == 5'd0);
        end else begin
          state_nxt = S_WAIT;
          div_nxt   = DIV_LOAD;
        end
      end

      S_WAIT: begin
        if (mode_run) begin
          if (div_cnt == '0) begin
            state_nxt  = S_SETTLE;
            idx_nxt    = idx + 4'd1;
            settle_nxt = SET_LOAD;
          end else begin
            div_nxt = div_cnt - DIV_W'(1);
          end
        end else begin
          // Holding the divider at its load value while manual means a
          // switch back to run always starts a fresh full tick.
          div_nxt = DIV_LOAD;
          if (step) begin
            state_nxt  = S_SETTLE;
            idx_nxt    = idx + 4'd1;
            settle_nxt = SET_LOAD;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_task2_vector_checker.sv
module tb_task2_vector_checker;
  localparam int          TICK_DIV  = 4;
  localparam int          SETTLE    = 2;
  localparam logic [15:0] XG        = 16'hCF00;
  localparam logic [15:0] YG        = 16'h0F54;
  // Edges from the start-accepting edge until done is seen: 16 vectors of
  // settle+check, plus 15 waits between them.
  localparam int          SWEEP_CYC = 16 * (SETTLE + 1) + 15 * TICK_DIV;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       mode_run = 1'b1;
  logic       a, b, c, d, x, y;
  logic [3:0] idx;
  logic       busy, done, pass, err_flag;
  logic [4:0] err_count;
`ifdef TASK2_CHK_ERRVEC_EN
  logic [15:0] err_vec;
`endif

  // Behavioural Task2: response tables indexed by the applied input code.
  logic [15:0] xv = XG;
  logic [15:0] yv = YG;
  assign x = xv[{a, b, c, d}];
  assign y = yv[{a, b, c, d}];

  int vectors = 0;
  int miscompares = 0;

  task2_vector_checker #(
    .TICK_DIV(TICK_DIV),
    .SETTLE  (SETTLE),
    .X_MASK  (XG),
    .Y_MASK  (YG)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .step     (step),
    .mode_run (mode_run),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .x        (x),
    .y        (y),
    .idx      (idx),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .err_flag (err_flag)
`ifdef TASK2_CHK_ERRVEC_EN
    ,
    .err_vec  (err_vec)
`endif
  );

  always #5 clock = ~clock;

  // Observation of the sweep as a whole.
  logic        mon_en = 1'b0;
  int          flag_cnt;
  logic [15:0] flag_mask;
  int          seq[$];
  int          last_idx;
  int          abcd_bad;

  always @(negedge clock) begin
    if (mon_en) begin
      if (err_flag === 1'b1) begin
        flag_cnt++;
        flag_mask[idx] = 1'b1;
      end
      if (busy === 1'b1 && int'(idx) != last_idx) begin
        seq.push_back(int'(idx));
        last_idx = int'(idx);
      end
      if ({a, b, c, d} !== idx) abcd_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " idx"}, 32'(idx), 32'd0);
    chk({tag, " abcd"}, 32'({a, b, c, d}), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " pass"}, 32'(pass), 32'd0);
    chk({tag, " err_count"}, 32'(err_count), 32'd0);
    chk({tag, " err_flag"}, 32'(err_flag), 32'd0);
`ifdef TASK2_CHK_ERRVEC_EN
    chk({tag, " err_vec"}, 32'(err_vec), 32'd0);
`endif
  endtask

  // Full run-mode sweep with the given Task2 responses; expectations come
  // from comparing the responses with the golden truth table.
  task automatic do_sweep(input logic [15:0] xr, input logic [15:0] yr,
                          input string name, input bit with_step);
    logic [15:0] em;
    int          expc;
    int          cycles;
    int          bad;
    logic [4:0]  ec_hold;
    em   = (xr ^ XG) | (yr ^ YG);
    expc = $countones(em);
    @(negedge clock);
    xv        = xr;
    yv        = yr;
    mode_run  = 1'b1;
    flag_cnt  = 0;
    flag_mask = 16'd0;
    seq.delete();
    last_idx  = -1;
    abcd_bad  = 0;
    mon_en    = 1'b1;
    start     = 1'b1;
    step      = with_step;
    @(negedge clock);
    start = 1'b0;
    step  = 1'b0;
    chk({name, " start busy"}, 32'(busy), 32'd1);
    chk({name, " start done"}, 32'(done), 32'd0);
    chk({name, " start err_count"}, 32'(err_count), 32'd0);
    chk({name, " start idx"}, 32'(idx), 32'd0);
    cycles = 0;
    while (done !== 1'b1 && cycles < 2000) begin
      @(negedge clock);
      cycles++;
    end
    #1;
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " cycles"}, 32'(cycles), 32'(SWEEP_CYC));
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " err_count"}, 32'(err_count), 32'(expc));
    chk({name, " pass"}, 32'(pass), (expc == 0) ? 32'd1 : 32'd0);
    chk({name, " flag pulses"}, 32'(flag_cnt), 32'(expc));
    chk({name, " flag vectors"}, 32'(flag_mask), 32'(em));
`ifdef TASK2_CHK_ERRVEC_EN
    chk({name, " err_vec"}, 32'(err_vec), 32'(em));
`endif
    chk({name, " idx count"}, 32'(seq.size()), 32'd16);
    bad = 0;
    foreach (seq[i]) if (seq[i] != i) bad++;
    chk({name, " idx order"}, 32'(bad), 32'd0);
    chk({name, " abcd track"}, 32'(abcd_bad), 32'd0);
    ec_hold = err_count;
    repeat (5) @(negedge clock);
    chk({name, " hold done"}, 32'(done), 32'd1);
    chk({name, " hold idx"}, 32'(idx), 32'd15);
    chk({name, " hold err_count"}, 32'(err_count), 32'(ec_hold));
    chk({name, " no late flag"}, 32'(flag_cnt), 32'(expc));
    mon_en = 1'b0;
  endtask

  initial begin : stim
    int n;
    logic [15:0] em;
    logic [15:0] rx, ry;

    // reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk_reset("idle");

    // healthy Task2, then forced y=0, then forced x=1
    do_sweep(XG, YG, "golden", 1'b0);
    do_sweep(XG, 16'h0000, "y_low", 1'b0);
    chk("y_low count const", 32'(err_count), 32'd7);
    do_sweep(16'hFFFF, YG, "x_high", 1'b0);
    chk("x_high count const", 32'(err_count), 32'd10);

    // random fault patterns
    for (int k = 0; k < 4; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      do_sweep(rx, ry, $sformatf("rand%0d", k), 1'b0);
    end

    // start and step together in DONE: start wins, no extra advance
    do_sweep(XG, YG, "start_step", 1'b1);

    // manual mode
    @(negedge clock);
    xv = XG;
    yv = YG;
    mode_run = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    repeat (6) @(negedge clock);
    chk("man step in settle", 32'(idx), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
    end
    chk("man idx", 32'(idx), 32'd5);
    chk("man busy", 32'(busy), 32'd1);
    chk("man abcd", 32'({a, b, c, d}), 32'b0101);
    chk("man done", 32'(done), 32'd0);

    // manual -> run: a full tick from a fresh divider
    mode_run = 1'b1;
    n = 0;
    while (idx == 4'd5 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("man->run tick", 32'(n), 32'(TICK_DIV));
    // run -> manual partway through a WAIT abandons the tick
    repeat (5) @(negedge clock);
    mode_run = 1'b0;
    repeat (10) @(negedge clock);
    chk("run->man hold", 32'(idx), 32'd6);
    mode_run = 1'b1;
    n = 0;
    while (idx == 4'd6 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("tick restart", 32'(n), 32'(TICK_DIV));
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("man finish done", 32'(done), 32'd1);
    chk("man finish pass", 32'(pass), 32'd1);
    chk("man finish err", 32'(err_count), 32'd0);

    // reset mid-sweep at idx 9, with y forced low so errors are pending
    @(negedge clock);
    xv = XG;
    yv = 16'h0000;
    mode_run = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (idx != 4'd9 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("mid idx 9 reached", 32'(idx), 32'd9);
    em = YG & 16'h01FF;
    chk("mid err_count", 32'(err_count), 32'($countones(em)));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("mid reset");
    @(negedge clock);
    reset_n = 1'b1;
    do_sweep(XG, YG, "after_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
